uart_transmitter: RTL and testbench

- Drains 32-bit words from a read FIFO and serialises them on an RS232 TX line: 8N1 frames, one byte per frame, most-significant byte first.
- Mirrors uart_receiver, so a word received by uart_receiver and sent back by this block comes out byte-for-byte in the original order.
- Sits in the clk_fifo domain, between a user FIFO (e.g. a DDR read-back path) and the board UART pin.

---
 rtl/uart_transmitter.sv | 148 ++++++++++++++
 tb/tb_uart_transmitter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// uart_transmitter: drains 32-bit words from a read FIFO and sends them as
// 8N1 UART frames, most-significant byte first, LSB first within each byte.
// Bytes of one word go out back to back. At least one idle cycle follows each word.
module uart_transmitter #(
  parameter int unsigned UART_BPS      = 'd1_500_000,
  parameter int unsigned CLK_FREQ      = 'd100_000_000,
  parameter int unsigned FIFO_RD_WIDTH = 'd32,
  parameter int unsigned FIFO_RD_BYTE  = 'd4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  input  logic [FIFO_RD_WIDTH-1:0] fifo_rd_data,
  output logic                     tx,
  output logic                     busy,
  output logic                     word_done
);

  localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int unsigned BAUD_W       = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam int unsigned BYTE_W       = (FIFO_RD_BYTE > 1) ? $clog2(FIFO_RD_BYTE) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT_MAX - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(FIFO_RD_BYTE - 1);
  localparam logic [3:0]        BIT_LAST_DATA = 4'd8;
  localparam logic [3:0]        BIT_STOP      = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    LOAD,
    SEND
  } state_t;

  state_t                   state_q, state_d;
  logic [BAUD_W-1:0]        baud_cnt_q, baud_cnt_d;
  logic [3:0]               bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0]        byte_idx_q, byte_idx_d;
  logic [FIFO_RD_WIDTH-1:0] word_q, word_d;
  logic                     tx_q, tx_d;
  logic                     rd_en_q, rd_en_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [7:0]               cur_byte;
  logic                     bit_end;

  assign bit_end = (baud_cnt_q == BAUD_LAST);

  // Byte of the held word currently being serialised.
  always_comb begin
    cur_byte = '0;
    for (int unsigned i = 0; i < FIFO_RD_BYTE; i++) begin
      if (byte_idx_q == BYTE_W'(i)) cur_byte = word_q[i*8 +: 8];
    end
  end

  // Next-state and next-output logic. tx_d is the level of the bit that
  // starts on the next cycle, so tx is a plain flop with no output decode.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    tx_d       = tx_q;
    rd_en_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (!fifo_empty) begin
          state_d = READ;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      READ: begin
        state_d = LOAD;
      end
      LOAD: begin
        word_d     = fifo_rd_data;
        byte_idx_d = BYTE_LAST;
        baud_cnt_d = '0;
        bit_idx_d  = '0;
        tx_d       = 1'b0;
        state_d    = SEND;
      end
      SEND: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          if (bit_idx_q == BIT_STOP) begin
            bit_idx_d = '0;
            if (byte_idx_q != '0) begin
              byte_idx_d = byte_idx_q - BYTE_W'(1);
              tx_d       = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            tx_d      = (bit_idx_q == BIT_LAST_DATA) ? 1'b1 : cur_byte[bit_idx_q[2:0]];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset forces the line idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      tx_q       <= 1'b1;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      tx_q       <= tx_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign word_done  = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter: instance 0 uses default parameters (66-cycle
// bit), instance 1 uses CLK_FREQ=8/UART_BPS=1 (8-cycle bit). Each instance is
// fed by a small latency-1 FIFO model.
module tb_uart_transmitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty_s [2];
  logic        rd_en_s      [2];
  logic [31:0] rd_data_s    [2];
  logic        tx_s         [2];
  logic        busy_s       [2];
  logic        done_s       [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] mem [2][16];
  int          wr_cnt [2];
  int          rd_ptr [2];

  localparam int BP0 = 66;
  localparam int BP1 = 8;

  typedef struct {
    int          dut;
    logic [31:0] word;
    logic [7:0]  b [4];
    int          lat;
    bit          b2b;
    string       name;
  } vec_t;

  localparam int NV = 5;
  vec_t vec [NV];

  uart_transmitter u_def (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty_s[0]),
    .fifo_rd_en   (rd_en_s[0]),
    .fifo_rd_data (rd_data_s[0]),
    .tx           (tx_s[0]),
    .busy         (busy_s[0]),
    .word_done    (done_s[0])
  );

  uart_transmitter #(
    .UART_BPS (1),
    .CLK_FREQ (8)
  ) u_small (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty_s[1]),
    .fifo_rd_en   (rd_en_s[1]),
    .fifo_rd_data (rd_data_s[1]),
    .tx           (tx_s[1]),
    .busy         (busy_s[1]),
    .word_done    (done_s[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign fifo_empty_s[0] = (rd_ptr[0] >= wr_cnt[0]);
  assign fifo_empty_s[1] = (rd_ptr[1] >= wr_cnt[1]);

  // FIFO model: data appears the cycle after a read request.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rd_en_s[d]) begin
        rd_data_s[d] <= mem[d][rd_ptr[d]];
        rd_ptr[d]    <= rd_ptr[d] + 1;
      end
    end
  end

  initial begin
    #(10 * 100000);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [31:0] w);
    mem[d][wr_cnt[d]] = w;
    wr_cnt[d] = wr_cnt[d] + 1;
  endtask

  function automatic int bp_of(input int d);
    return (d == 0) ? BP0 : BP1;
  endfunction

  // Waits for a read pulse, then walks every cycle of the word comparing
  // tx/busy/word_done/fifo_rd_en against the expected frame sequence.
  task automatic run_word(input int d, input logic [7:0] exp_b [4], input int exp_lat,
                          input int exp_c0, input string name, output int done_cyc);
    int         bp;
    int         c0;
    int         j, by, bi;
    int         e_tx, e_busy, e_rd, n_done, done_at;
    logic       exp_tx;
    logic [7:0] rx [4];
    bit         got;
    bp      = bp_of(d);
    got     = 1'b0;
    e_tx    = 0;
    e_busy  = 0;
    e_rd    = 0;
    n_done  = 0;
    done_at = -1;
    rx      = '{8'h00, 8'h00, 8'h00, 8'h00};
    for (int w = 0; w < 200 && !got; w++) begin
      @(negedge clk);
      if (rd_en_s[d] === 1'b1) got = 1'b1;
    end
    check({name, "_rd_seen"}, {31'd0, got}, 32'd1);
    if (!got) begin
      done_cyc = cyc;
      return;
    end
    c0 = cyc;
    if (exp_c0 >= 0) check({name, "_rd_cycle"}, c0, exp_c0);
    if (busy_s[d] !== 1'b1) e_busy++;
    if (tx_s[d] !== 1'b1) e_tx++;
    for (int k = 1; k <= 2 + 40 * bp; k++) begin
      @(negedge clk);
      j = k - 2;
      if (k == 1 || j >= 40 * bp) begin
        exp_tx = 1'b1;
      end else begin
        by = j / (10 * bp);
        bi = (j % (10 * bp)) / bp;
        if (bi == 0)      exp_tx = 1'b0;
        else if (bi == 9) exp_tx = 1'b1;
        else              exp_tx = exp_b[by][bi-1];
        if ((j % bp) == bp / 2 && bi >= 1 && bi <= 8) rx[by][bi-1] = tx_s[d];
      end
      if (tx_s[d] !== exp_tx) e_tx++;
      if (busy_s[d] !== ((k <= 1 + 40 * bp) ? 1'b1 : 1'b0)) e_busy++;
      if (rd_en_s[d] !== 1'b0) e_rd++;
      if (done_s[d] === 1'b1) begin
        n_done++;
        if (done_at < 0) done_at = k;
      end
    end
    for (int b = 0; b < 4; b++) check($sformatf("%s_byte%0d", name, b), {24'd0, rx[b]}, {24'd0, exp_b[b]});
    check({name, "_tx_cycle_errs"}, e_tx, 0);
    check({name, "_busy_errs"}, e_busy, 0);
    check({name, "_extra_rd"}, e_rd, 0);
    check({name, "_done_pulses"}, n_done, 1);
    check({name, "_latency"}, done_at, exp_lat);
    done_cyc = c0 + 2 + 40 * bp;
  endtask

  initial begin
    int         last_done;
    int         e_tx, e_rd, e_busy, e_done;
    bit         got;
    logic [7:0] eb [4];

    vec[0] = '{dut: 0, word: 32'hA53C0FF0, b: '{8'hA5, 8'h3C, 8'h0F, 8'hF0}, lat: 2642, b2b: 1'b0, name: "def_a53c"};
    vec[1] = '{dut: 1, word: 32'h01020304, b: '{8'h01, 8'h02, 8'h03, 8'h04}, lat: 322,  b2b: 1'b0, name: "w01020304"};
    vec[2] = '{dut: 1, word: 32'h80FF0055, b: '{8'h80, 8'hFF, 8'h00, 8'h55}, lat: 322,  b2b: 1'b1, name: "w80ff0055"};
    vec[3] = '{dut: 1, word: 32'h00000000, b: '{8'h00, 8'h00, 8'h00, 8'h00}, lat: 322,  b2b: 1'b0, name: "wzero"};
    vec[4] = '{dut: 1, word: 32'hFFFFFFFF, b: '{8'hFF, 8'hFF, 8'hFF, 8'hFF}, lat: 322,  b2b: 1'b1, name: "wones"};

    last_done = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_tx%0d", d), {31'd0, tx_s[d]}, 32'd1);
      check($sformatf("reset_rd%0d", d), {31'd0, rd_en_s[d]}, 32'd0);
      check($sformatf("reset_busy%0d", d), {31'd0, busy_s[d]}, 32'd0);
      check($sformatf("reset_done%0d", d), {31'd0, done_s[d]}, 32'd0);
    end
    rst = 1'b0;

    // Idle with an empty FIFO: nothing may move.
    e_tx = 0; e_rd = 0; e_busy = 0; e_done = 0;
    repeat (1000) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (tx_s[d] !== 1'b1)    e_tx++;
        if (rd_en_s[d] !== 1'b0) e_rd++;
        if (busy_s[d] !== 1'b0)  e_busy++;
        if (done_s[d] !== 1'b0)  e_done++;
      end
    end
    check("idle_tx_errs", e_tx, 0);
    check("idle_rd_errs", e_rd, 0);
    check("idle_busy_errs", e_busy, 0);
    check("idle_done_errs", e_done, 0);

    // Table: words marked b2b are preloaded with their predecessor.
    for (int i = 0; i < NV; i++) begin
      if (!vec[i].b2b) begin
        push(vec[i].dut, vec[i].word);
        for (int k = i + 1; k < NV && vec[k].b2b; k++) push(vec[k].dut, vec[k].word);
      end
      run_word(vec[i].dut, vec[i].b, vec[i].lat, vec[i].b2b ? last_done + 1 : -1,
               vec[i].name, last_done);
    end
    check("rd_pulses_def", rd_ptr[0], 1);
    check("rd_pulses_small", rd_ptr[1], 4);

    // Reset in the middle of the second byte (0x22, data bit 3 = 0).
    push(1, 32'h11223344);
    got = 1'b0;
    for (int w = 0; w < 200 && !got; w++) begin
      @(negedge clk);
      if (rd_en_s[1] === 1'b1) got = 1'b1;
    end
    check("abort_rd_seen", {31'd0, got}, 32'd1);
    repeat (1 + 14 * BP1 + BP1 / 2) @(negedge clk);
    check("abort_pre_tx", {31'd0, tx_s[1]}, 32'd0);
    #1 rst = 1'b1;
    #1;
    check("abort_async_tx", {31'd0, tx_s[1]}, 32'd1);
    check("abort_async_busy", {31'd0, busy_s[1]}, 32'd0);
    repeat (3) @(negedge clk);
    check("abort_hold_tx", {31'd0, tx_s[1]}, 32'd1);
    push(1, 32'hC3A55A3C);
    rst = 1'b0;
    eb = '{8'hC3, 8'hA5, 8'h5A, 8'h3C};
    run_word(1, eb, 322, -1, "post_rst", last_done);
    check("abort_reads", rd_ptr[1], 6);

    // FIFO becomes non-empty mid-word: next read only after word_done.
    push(1, 32'h5A5A1234);
    eb = '{8'h5A, 8'h5A, 8'h12, 8'h34};
    fork
      run_word(1, eb, 322, -1, "mid_w1", last_done);
      begin
        repeat (40) @(negedge clk);
        push(1, 32'h9C6E0181);
      end
    join
    check("mid_no_early_rd", rd_ptr[1], 7);
    eb = '{8'h9C, 8'h6E, 8'h01, 8'h81};
    run_word(1, eb, 322, last_done + 1, "mid_w2", last_done);
    check("mid_reads", rd_ptr[1], 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
